// File: rtl/sync_signal_monitor.sv
// sync_signal_monitor: synchronises an external level, strobes its edges and measures the
// width of each high pulse in clk cycles, presenting results on a one-entry valid/ready slot.
// Optional glitch filter on level_out: define SYNC_SIGNAL_MONITOR_GLITCH_FILTER_EN.
module sync_signal_monitor #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MIN_WIDTH   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             signal_in,
   input  logic             en,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             width_valid,
   input  logic             width_ready,
   output logic [CNT_W-1:0] width_data,
   output logic             width_ovf,
   output logic             overrun,
   input  logic             clr
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StMeasure = 1'b1;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   // Reject illegal parameterisations at elaboration.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || MIN_WIDTH < 1 || MIN_WIDTH > 15) begin : gen_param_err
      $error("sync_signal_monitor: SYNC_STAGES must be 2..4 and MIN_WIDTH 1..15");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_out;
   logic                   prev_q, prev_d;
   logic [0:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   result_evt;
   logic                   xfer;
   logic                   valid_q, valid_d;
   logic [CNT_W-1:0]       data_q, data_d;
   logic                   wovf_q, wovf_d;
   logic                   overrun_q, overrun_d;

   // Shift signal_in through the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SYNC_SIGNAL_MONITOR_GLITCH_FILTER_EN
   logic [3:0] filt_cnt_q, filt_cnt_d;
   logic       level_q, level_d;

   // Accept a new level only after it has persisted MIN_WIDTH consecutive cycles.
   always_comb begin
      filt_cnt_d = 4'd0;
      level_d    = level_q;
      if (sync_out != level_q) begin
         if (filt_cnt_q == 4'(MIN_WIDTH - 1)) begin
            level_d = sync_out;
         end else begin
            filt_cnt_d = filt_cnt_q + 4'd1;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_cnt_q <= 4'd0;
         level_q    <= 1'b0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
         level_q    <= level_d;
      end
   end

   assign level_out = level_q;
`else
   assign level_out = sync_out;
`endif

   // Edge detector: prev is level_out delayed one cycle.
   always_comb begin
      prev_d     = level_out;
      rise_pulse = level_out & ~prev_q;
      fall_pulse = ~level_out & prev_q;
   end

   // Measurement FSM: count high cycles from an enabled rise up to the fall.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      result_evt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rise_pulse && en) begin
               state_d = StMeasure;
               cnt_d   = CntOne;
               ovf_d   = 1'b0;
            end
         end
         StMeasure: begin
            if (!en) begin
               // Abandon: a partially enabled pulse is never reported.
               state_d = StIdle;
               ovf_d   = 1'b0;
            end else if (fall_pulse) begin
               result_evt = 1'b1;
               state_d    = StIdle;
               ovf_d      = 1'b0;
            end else if (cnt_q == {CNT_W{1'b1}}) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Result slot: load when empty or draining on this edge, otherwise drop and flag overrun.
   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      wovf_d    = wovf_q;
      overrun_d = overrun_q;
      xfer      = valid_q & width_ready;
      if (xfer) begin
         valid_d = 1'b0;
      end
      if (clr) begin
         overrun_d = 1'b0;
      end
      if (result_evt) begin
         if (!valid_q || xfer) begin
            valid_d = 1'b1;
            data_d  = cnt_q;
            wovf_d  = ovf_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         state_q   <= StIdle;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         wovf_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         wovf_q    <= wovf_d;
         overrun_q <= overrun_d;
      end
   end

   assign width_valid = valid_q;
   assign width_data  = data_q;
   assign width_ovf   = wovf_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_sync_signal_monitor.sv
// Bench for sync_signal_monitor: directed and random pulses checked against a pulse-level
// reference model; completed widths go through a scoreboard queue drained by a monitor.
module tb_sync_signal_monitor;

   localparam int unsigned SyncStages = 2;
   localparam int unsigned CntW       = 8;
   localparam int unsigned MinWidth   = 3;
   localparam int unsigned CntMax     = (1 << CntW) - 1;
   localparam int          HistLen    = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            signal_in;
   logic            en;
   logic            width_ready;
   logic            clr;
   logic            level_out;
   logic            rise_pulse;
   logic            fall_pulse;
   logic            width_valid;
   logic [CntW-1:0] width_data;
   logic            width_ovf;
   logic            overrun;

   sync_signal_monitor #(
      .SYNC_STAGES(SyncStages),
      .CNT_W      (CntW),
      .MIN_WIDTH  (MinWidth)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .signal_in  (signal_in),
      .en         (en),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .width_valid(width_valid),
      .width_ready(width_ready),
      .width_data (width_data),
      .width_ovf  (width_ovf),
      .overrun    (overrun),
      .clr        (clr)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      int unsigned data;
      bit          ovf;
   } result_t;

   result_t exp_q[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model state: in_hist[k] is signal_in as seen k cycles ago.
   bit          in_hist [HistLen];
   bit          m_lvl_prev;
   bit          m_active;
   bit          m_en_all;
   bit          m_occ;
   bit          m_ovr;
   int unsigned m_len;

   // Expected level: the input delayed by the synchroniser, optionally debounced.
   function automatic bit model_level();
`ifdef SYNC_SIGNAL_MONITOR_GLITCH_FILTER_EN
      bit all_diff = 1'b1;
      for (int k = 1; k <= int'(MinWidth); k++) begin
         if (in_hist[SyncStages + k] == m_lvl_prev) all_diff = 1'b0;
      end
      return all_diff ? ~m_lvl_prev : m_lvl_prev;
`else
      return in_hist[SyncStages];
`endif
   endfunction

   // Model: a pulse is reported iff en held from its rise cycle through its fall cycle.
   initial begin : model
      bit      lvl, rise, fall, evt, xfer, drop, clear_q, push;
      result_t item;
      item = '{data: 0, ovf: 1'b0};
      forever begin
         @(negedge clk);
         clear_q = 1'b0;
         push    = 1'b0;
         if (!rst_n) begin
            for (int k = 0; k < HistLen; k++) in_hist[k] = 1'b0;
            m_lvl_prev = 1'b0;
            m_active   = 1'b0;
            m_occ      = 1'b0;
            m_ovr      = 1'b0;
            clear_q    = 1'b1;
            check("rst_level_out", level_out, 0);
            check("rst_rise_pulse", rise_pulse, 0);
            check("rst_fall_pulse", fall_pulse, 0);
            check("rst_width_valid", width_valid, 0);
            check("rst_width_data", width_data, 0);
            check("rst_width_ovf", width_ovf, 0);
            check("rst_overrun", overrun, 0);
         end else begin
            for (int k = HistLen - 1; k > 0; k--) in_hist[k] = in_hist[k-1];
            in_hist[0] = signal_in;
            lvl  = model_level();
            rise = lvl & ~m_lvl_prev;
            fall = ~lvl & m_lvl_prev;
            check("level_out", level_out, lvl);
            check("rise_pulse", rise_pulse, rise);
            check("fall_pulse", fall_pulse, fall);
            check("overrun", overrun, m_ovr);
            evt = 1'b0;
            if (rise) begin
               m_active = 1'b1;
               m_len    = 1;
               m_en_all = en;
            end else if (m_active && lvl) begin
               m_len++;
               m_en_all &= en;
            end else if (m_active && fall) begin
               m_en_all &= en;
               m_active  = 1'b0;
               evt       = m_en_all;
            end
            xfer = m_occ & width_ready;
            drop = 1'b0;
            if (evt) begin
               if (!m_occ || xfer) begin
                  push      = 1'b1;
                  item.data = (m_len > CntMax) ? CntMax : m_len;
                  item.ovf  = (m_len > CntMax);
                  m_occ     = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end else if (xfer) begin
               m_occ = 1'b0;
            end
            if (clr) m_ovr = 1'b0;
            if (drop) m_ovr = 1'b1;
            m_lvl_prev = lvl;
         end
         // Queue updates land on the edge so the monitor never races them.
         @(posedge clk);
         if (clear_q) exp_q.delete();
         if (push) exp_q.push_back(item);
      end
   end

   // Monitor: the slot must hold exactly the head of the scoreboard; pop on transfer.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("width_valid", width_valid, exp_q.size() != 0);
            if (width_valid && exp_q.size() != 0) begin
               check("width_data", width_data, exp_q[0].data);
               check("width_ovf", width_ovf, exp_q[0].ovf);
               if (width_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      signal_in = 1'b1;
      step(hi);
      signal_in = 1'b0;
      step(lo);
   endtask

   task automatic step_rand(input int n);
      repeat (n) begin
         en          = ($urandom_range(0, 99) < 95);
         width_ready = 1'($urandom_range(0, 1));
         clr         = ($urandom_range(0, 19) == 0);
         step(1);
      end
   endtask

   initial begin : stim
      int hi, lo;
      rst_n       = 1'b0;
      signal_in   = 1'b0;
      en          = 1'b1;
      width_ready = 1'b1;
      clr         = 1'b0;
      // Reset held while the input toggles.
      for (int i = 0; i < 4; i++) begin
         signal_in = i[0];
         step(1);
      end
      rst_n     = 1'b1;
      signal_in = 1'b0;
      step(4);
      // Basic width and saturation boundaries.
      pulse(5, 8);
      pulse(300, 6);
      pulse(10, 6);
      pulse(255, 6);
      pulse(256, 6);
      // Full slot: second result dropped, then drain and clear.
      width_ready = 1'b0;
      pulse(3, 8);
      pulse(7, 8);
      width_ready = 1'b1;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(3);
      // en dropped mid-pulse, and en raised while already high.
      signal_in = 1'b1;
      step(4);
      en = 1'b0;
      step(2);
      en = 1'b1;
      step(4);
      signal_in = 1'b0;
      step(6);
      en        = 1'b0;
      signal_in = 1'b1;
      step(5);
      en = 1'b1;
      step(4);
      signal_in = 1'b0;
      step(6);
      // Back-to-back pulses and short glitches.
      pulse(4, 1);
      pulse(4, 1);
      pulse(2, 8);
      pulse(1, 6);
      pulse(6, 10);
      // Reset asserted mid-measure, then a normal pulse.
      signal_in = 1'b1;
      step(6);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);
      signal_in = 1'b0;
      step(6);
      pulse(5, 8);
      // Random pulses with random enable, back-pressure and clears.
      for (int n = 0; n < 150; n++) begin
         hi        = int'($urandom_range(1, 24));
         lo        = int'($urandom_range(1, 8));
         signal_in = 1'b1;
         step_rand(hi);
         signal_in = 1'b0;
         step_rand(lo);
      end
      en          = 1'b1;
      width_ready = 1'b1;
      clr         = 1'b0;
      signal_in   = 1'b0;
      step(20);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
